// File: rtl/tcp_poll_pkg.sv
// Shared types and constants for the TCP bridge poll scheduler.
package tcp_poll_pkg;

    localparam int unsigned STATUS_W = 32;

    localparam logic OP_RECV = 1'b0;
    localparam logic OP_SEND = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Distance of idx from the scan start ptr, walking upward modulo n.
    function automatic int unsigned rr_dist(input int unsigned idx,
                                            input int unsigned ptr,
                                            input int unsigned n);
        return (idx >= ptr) ? (idx - ptr) : (idx + n - ptr);
    endfunction

endpackage

// File: rtl/tcp_rr_pick.sv
// Combinational round-robin first-set finder starting at i_ptr.
module tcp_rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    int unsigned w_pos;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_pos = 32'(i_ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            if (!o_found && i_req[IW'(w_pos)]) begin
                o_found = 1'b1;
                o_idx   = IW'(w_pos);
            end
        end
    end

endmodule

// File: rtl/tcp_poll_scheduler.sv
// Round-robin sequencer sharing one VPI TCP bridge command port across NUM_CH
// channels, with one tx and one rx holding register per channel.
module tcp_poll_scheduler
    import tcp_poll_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                         aclk,
    input  logic                         arstn,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_tx_data,
    input  logic [NUM_CH-1:0]            s_tx_valid,
    output logic [NUM_CH-1:0]            s_tx_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] m_rx_data,
    output logic [NUM_CH-1:0]            m_rx_valid,
    input  logic [NUM_CH-1:0]            m_rx_ready,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic                         cmd_op,
    output logic [$clog2(NUM_CH)-1:0]    cmd_ch,
    output logic [DATA_WIDTH-1:0]        cmd_data,
    input  logic                         rsp_valid,
    input  logic [STATUS_W-1:0]          rsp_status,
    input  logic [DATA_WIDTH-1:0]        rsp_data,
    output logic [15:0]                  err_count,
    output logic                         timeout_pulse
);

    localparam int unsigned CHW = $clog2(NUM_CH);
    localparam int unsigned TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t                r_state;
    state_t                w_state_next;
    logic [NUM_CH-1:0]     r_tx_full;
    logic [DATA_WIDTH-1:0] r_tx_data [NUM_CH];
    logic [NUM_CH-1:0]     r_rx_full;
    logic [DATA_WIDTH-1:0] r_rx_data [NUM_CH];
    logic [CHW-1:0]        r_cur_ch;
    logic [CHW-1:0]        r_last_ch;
    logic                  r_cur_op;
    logic [DATA_WIDTH-1:0] r_cur_data;
    logic                  r_cmd_valid;
    logic [TOW-1:0]        r_to_cnt;
    logic [15:0]           r_err_count;
    logic                  r_timeout_pulse;

    logic [CHW-1:0]        w_start;
    logic [CHW-1:0]        w_send_idx;
    logic [CHW-1:0]        w_recv_idx;
    logic                  w_send_found;
    logic                  w_recv_found;
    logic                  w_pick_send;
    logic                  w_pick_any;
    logic [CHW-1:0]        w_pick_ch;
    logic                  w_issue_load;
    logic                  w_handshake;
    logic                  w_rsp_take;
    logic                  w_timeout;
    logic                  w_stat_pos;
    logic                  w_stat_neg;

    assign w_start = (r_last_ch == CHW'(NUM_CH - 1)) ? '0 : r_last_ch + CHW'(1);

    tcp_rr_pick #(.N(NUM_CH), .IW(CHW)) u_pick_send (
        .i_req   (r_tx_full),
        .i_ptr   (w_start),
        .o_idx   (w_send_idx),
        .o_found (w_send_found)
    );

    tcp_rr_pick #(.N(NUM_CH), .IW(CHW)) u_pick_recv (
        .i_req   (~r_rx_full),
        .i_ptr   (w_start),
        .o_idx   (w_recv_idx),
        .o_found (w_recv_found)
    );

    // Whichever channel comes first in scan order wins; a send only beats a receive on the same channel.
    always_comb begin
        w_pick_send = w_send_found &&
                      (!w_recv_found ||
                       (rr_dist(32'(w_send_idx), 32'(w_start), NUM_CH) <=
                        rr_dist(32'(w_recv_idx), 32'(w_start), NUM_CH)));
        w_pick_any  = w_send_found || w_recv_found;
        w_pick_ch   = w_pick_send ? w_send_idx : w_recv_idx;
    end

    assign w_stat_pos = $signed(rsp_status) > 32'sd0;
    assign w_stat_neg = rsp_status[STATUS_W-1];

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_pick_any) w_state_next = ST_ISSUE;
            ST_ISSUE: if (cmd_ready)  w_state_next = ST_WAIT;
            ST_WAIT:  if (rsp_valid || w_timeout) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_issue_load = 1'b0;
        w_handshake  = 1'b0;
        w_rsp_take   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE:  w_issue_load = w_pick_any;
            ST_ISSUE: w_handshake  = cmd_ready;
            ST_WAIT: begin
                w_rsp_take = rsp_valid;
                w_timeout  = !rsp_valid && (r_to_cnt == TOW'(TIMEOUT - 1));
            end
            default: ;
        endcase
    end

    // Command register and arbitration bookkeeping.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_cmd_valid     <= 1'b0;
            r_cur_op        <= OP_RECV;
            r_cur_ch        <= '0;
            r_cur_data      <= '0;
            r_last_ch       <= CHW'(NUM_CH - 1);
            r_to_cnt        <= '0;
            r_err_count     <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= w_timeout;
            if (w_issue_load) begin
                r_cmd_valid <= 1'b1;
                r_cur_op    <= w_pick_send ? OP_SEND : OP_RECV;
                r_cur_ch    <= w_pick_ch;
                r_cur_data  <= w_pick_send ? r_tx_data[w_pick_ch] : '0;
            end else if (w_handshake) begin
                r_cmd_valid <= 1'b0;
                r_last_ch   <= r_cur_ch;
            end
            if (w_handshake) begin
                r_to_cnt <= '0;
            end else if (r_state == ST_WAIT && !rsp_valid && !w_timeout) begin
                r_to_cnt <= r_to_cnt + TOW'(1);
            end
            if (((w_rsp_take && w_stat_neg) || w_timeout) && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    // Per-channel holding registers; accept and clear can never coincide on one channel.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_tx_full <= '0;
            r_rx_full <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_tx_data[i] <= '0;
                r_rx_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (s_tx_valid[i] && !r_tx_full[i]) begin
                    r_tx_full[i] <= 1'b1;
                    r_tx_data[i] <= s_tx_data[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (w_rsp_take && (r_cur_op == OP_SEND) && w_stat_pos &&
                             (r_cur_ch == CHW'(i))) begin
                    r_tx_full[i] <= 1'b0;
                end
                if (m_rx_ready[i] && r_rx_full[i]) begin
                    r_rx_full[i] <= 1'b0;
                end else if (w_rsp_take && (r_cur_op == OP_RECV) && w_stat_pos &&
                             (r_cur_ch == CHW'(i))) begin
                    r_rx_full[i] <= 1'b1;
                    r_rx_data[i] <= rsp_data;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_rx_out
        assign m_rx_data[g*DATA_WIDTH +: DATA_WIDTH] = r_rx_data[g];
    end

    assign s_tx_ready    = ~r_tx_full;
    assign m_rx_valid    = r_rx_full;
    assign cmd_valid     = r_cmd_valid;
    assign cmd_op        = r_cur_op;
    assign cmd_ch        = r_cur_ch;
    assign cmd_data      = r_cur_data;
    assign err_count     = r_err_count;
    assign timeout_pulse = r_timeout_pulse;

endmodule

// File: tb/tb_tcp_poll_scheduler.sv
// Directed bench for tcp_poll_scheduler with a hand-driven bridge (2 channels, TIMEOUT 16).
module tb_tcp_poll_scheduler;

    logic        aclk = 1'b0;
    logic        arstn;
    logic [63:0] s_tx_data;
    logic [1:0]  s_tx_valid;
    logic [1:0]  s_tx_ready;
    logic [63:0] m_rx_data;
    logic [1:0]  m_rx_valid;
    logic [1:0]  m_rx_ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [0:0]  cmd_ch;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_status;
    logic [31:0] rsp_data;
    logic [15:0] err_count;
    logic        timeout_pulse;

    int n_checks = 0;
    int n_errors = 0;

    always #5 aclk = ~aclk;

    tcp_poll_scheduler #(.NUM_CH(2), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .aclk          (aclk),
        .arstn         (arstn),
        .s_tx_data     (s_tx_data),
        .s_tx_valid    (s_tx_valid),
        .s_tx_ready    (s_tx_ready),
        .m_rx_data     (m_rx_data),
        .m_rx_valid    (m_rx_valid),
        .m_rx_ready    (m_rx_ready),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_ch        (cmd_ch),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_status    (rsp_status),
        .rsp_data      (rsp_data),
        .err_count     (err_count),
        .timeout_pulse (timeout_pulse)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Accept the pending command, then answer it on the following cycle.
    task automatic serve(input logic [31:0] status, input logic [31:0] data);
        cmd_ready = 1'b1;
        tick();
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b1;
        rsp_status = status;
        rsp_data   = data;
        tick();
        rsp_valid  = 1'b0;
    endtask

    initial begin
        int wait_n;
        arstn      = 1'b0;
        s_tx_data  = '0;
        s_tx_valid = '0;
        m_rx_ready = '0;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_status = '0;
        rsp_data   = '0;
        repeat (5) tick();
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_cmd_fields", {31'd0, cmd_op, cmd_ch, cmd_data}, 64'd0);
        chk("rst_tx_ready", 64'(s_tx_ready), 64'h3);
        chk("rst_rx_valid", 64'(m_rx_valid), 64'h0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_to_pulse", 64'(timeout_pulse), 64'd0);

        arstn = 1'b1;
        tick();
        chk("first_cmd", {cmd_valid, cmd_op, 7'd0, cmd_ch}, {1'b1, 1'b0, 8'd0});
        tick();
        chk("first_cmd_hold", {cmd_valid, cmd_op, 7'd0, cmd_ch}, {1'b1, 1'b0, 8'd0});

        // Receive on ch0 lands in the rx register.
        serve(32'd4, 32'h12345678);
        chk("rx_valid", 64'(m_rx_valid), 64'h1);
        chk("rx_data", 64'(m_rx_data[31:0]), 64'h12345678);
        tick();
        chk("rx_next_ch1", {cmd_valid, cmd_op, 7'd0, cmd_ch}, {1'b1, 1'b0, 8'd1});
        serve(32'd0, 32'hFFFF0000);
        chk("rx_discard", 64'(m_rx_valid), 64'h1);
        tick();
        chk("rx_skip_ch0", {cmd_valid, cmd_op, 7'd0, cmd_ch}, {1'b1, 1'b0, 8'd1});

        // Echo: tx word on ch1.
        s_tx_valid = 2'b10;
        s_tx_data  = {32'hDEADBEEF, 32'h0};
        tick();
        s_tx_valid = 2'b00;
        chk("tx_accept", 64'(s_tx_ready), 64'h1);
        serve(32'd0, 32'h0);
        tick();
        chk("echo_cmd", {cmd_valid, cmd_op, cmd_ch, cmd_data}, {1'b1, 1'b1, 1'b1, 32'hDEADBEEF});
        serve(32'd4, 32'h0);
        chk("echo_tx_ready", 64'(s_tx_ready), 64'h3);

        m_rx_ready = 2'b01;
        tick();
        m_rx_ready = 2'b00;
        chk("rx_pop", 64'(m_rx_valid), 64'h0);

        // Error retry: ch0 send fails once, then goes again on its next turn.
        s_tx_valid = 2'b01;
        s_tx_data  = {32'h0, 32'hA5A5A5A5};
        tick();
        s_tx_valid = 2'b00;
        serve(32'd0, 32'h0);
        tick();
        chk("retry_cmd1", {cmd_valid, cmd_op, cmd_ch, cmd_data}, {1'b1, 1'b1, 1'b0, 32'hA5A5A5A5});
        serve(32'hFFFFFFFF, 32'h0);
        chk("retry_err", 64'(err_count), 64'd1);
        chk("retry_keep", 64'(s_tx_ready), 64'h2);
        tick();
        chk("retry_rr_ch1", {cmd_valid, cmd_op, 7'd0, cmd_ch}, {1'b1, 1'b0, 8'd1});
        serve(32'd0, 32'h0);
        tick();
        chk("retry_cmd2", {cmd_valid, cmd_op, cmd_ch, cmd_data}, {1'b1, 1'b1, 1'b0, 32'hA5A5A5A5});
        serve(32'd4, 32'h0);
        chk("retry_done", {s_tx_ready, err_count}, {2'b11, 16'd1});

        // Fairness: both channels kept full, bridge always ready and responding.
        cmd_ready  = 1'b1;
        s_tx_valid = 2'b11;
        s_tx_data  = {32'h22222222, 32'h11111111};
        tick();
        tick();
        rsp_valid  = 1'b1;
        rsp_status = 32'd0;
        tick();
        rsp_status = 32'd4;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fair_cmd", {cmd_valid, cmd_op, cmd_ch, cmd_data},
                {1'b1, 1'b1, 1'(k % 2), (k % 2 == 1) ? 32'h22222222 : 32'h11111111});
            tick();
            tick();
        end
        s_tx_valid = 2'b00;
        rsp_valid  = 1'b0;
        rsp_status = 32'd0;

        // Timeout: bridge never answers.
        tick();
        tick();
        cmd_ready = 1'b0;
        wait_n = 0;
        while (wait_n < 40 && !timeout_pulse) begin
            tick();
            wait_n++;
        end
        chk("to_latency", 64'(wait_n), 64'd16);
        chk("to_err", 64'(err_count), 64'd2);
        tick();
        chk("to_pulse_once", 64'(timeout_pulse), 64'd0);
        rsp_valid  = 1'b1;
        rsp_status = 32'hFFFFFFFF;
        tick();
        rsp_valid  = 1'b0;
        chk("stray_rsp", {cmd_valid, err_count}, {1'b1, 16'd2});

        // Asynchronous reset in ISSUE drops the command and the held word.
        #2 arstn = 1'b0;
        #1;
        chk("arst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("arst_state", {s_tx_ready, err_count}, {2'b11, 16'd0});
        repeat (3) tick();
        arstn = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
